axi_crossbar_w_route: RTL and testbench

AXI_CROSSBAR_W_ROUTE -- requirements
Module: axi_crossbar_w_route

---
 rtl/axi_crossbar_w_route.sv | 192 +++++++++++++++++++
 tb/tb_axi_crossbar_w_route.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_crossbar_w_route.sv
// W-channel router: steers each burst to the master picked by its queued command, or swallows it and answers DECERR.
// Optional AXI_XBAR_W_ROUTE_REG_EN adds a 2-entry skid on the master path (+1 cycle, full rate, registered ready).
module axi_crossbar_w_route #(
   parameter int M_COUNT    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int ID_WIDTH   = 8,
   parameter int CMD_DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(M_COUNT)-1:0] s_wc_select,
   input  logic                       s_wc_decerr,
   input  logic [ID_WIDTH-1:0]        s_wc_id,
   input  logic                       s_wc_valid,
   output logic                       s_wc_ready,
   input  logic [DATA_WIDTH-1:0]      s_axi_wdata,
   input  logic [STRB_WIDTH-1:0]      s_axi_wstrb,
   input  logic                       s_axi_wlast,
   input  logic                       s_axi_wvalid,
   output logic                       s_axi_wready,
   output logic [DATA_WIDTH-1:0]      m_axi_wdata,
   output logic [STRB_WIDTH-1:0]      m_axi_wstrb,
   output logic                       m_axi_wlast,
   output logic [M_COUNT-1:0]         m_axi_wvalid,
   input  logic [M_COUNT-1:0]         m_axi_wready,
   output logic [ID_WIDTH-1:0]        m_decerr_bid,
   output logic [1:0]                 m_decerr_bresp,
   output logic                       m_decerr_bvalid,
   input  logic                       m_decerr_bready
);
   localparam int SEL_W = $clog2(M_COUNT);
   localparam int AW    = $clog2(CMD_DEPTH);
   localparam int PW    = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ROUTE   = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   logic [SEL_W-1:0]    cmd_sel_mem [CMD_DEPTH];
   logic                cmd_dec_mem [CMD_DEPTH];
   logic [ID_WIDTH-1:0] cmd_id_mem  [CMD_DEPTH];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic                cmd_full, cmd_empty, cmd_push, cmd_pop;
   logic [SEL_W-1:0]    head_sel;
   logic                head_dec;
   logic [ID_WIDTH-1:0] head_id;

   logic [1:0]          state_q, state_d;
   logic                bvalid_q, bvalid_d;
   logic [ID_WIDTH-1:0] bid_q, bid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic                route_vld, route_rdy;

   // Extra pointer bit tells full (MSBs differ) from empty (pointers equal).
   assign cmd_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign cmd_empty = (wr_ptr_q == rd_ptr_q);
   assign s_wc_ready = ~rst & ~cmd_full;
   assign cmd_push  = s_wc_valid & s_wc_ready;
   assign head_sel  = cmd_sel_mem[rd_ptr_q[AW-1:0]];
   assign head_dec  = cmd_dec_mem[rd_ptr_q[AW-1:0]];
   assign head_id   = cmd_id_mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_sel_mem[wr_ptr_q[AW-1:0]] <= s_wc_select;
         cmd_dec_mem[wr_ptr_q[AW-1:0]] <= s_wc_decerr;
         cmd_id_mem[wr_ptr_q[AW-1:0]]  <= s_wc_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= ST_IDLE;
         bvalid_q <= 1'b0;
         bid_q    <= '0;
         bresp_q  <= 2'b00;
      end else begin
         if (cmd_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (cmd_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         state_q  <= state_d;
         bvalid_q <= bvalid_d;
         bid_q    <= bid_d;
         bresp_q  <= bresp_d;
      end
   end

   // The head stays queued for the whole burst and is popped only once it is fully done.
   always_comb begin
      state_d      = state_q;
      cmd_pop      = 1'b0;
      bvalid_d     = bvalid_q;
      bid_d        = bid_q;
      bresp_d      = bresp_q;
      s_axi_wready = 1'b0;
      route_vld    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!cmd_empty) state_d = head_dec ? ST_DISCARD : ST_ROUTE;
         end
         ST_ROUTE: begin
            route_vld    = s_axi_wvalid;
            s_axi_wready = route_rdy;
            if (s_axi_wvalid && route_rdy && s_axi_wlast) begin
               cmd_pop = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DISCARD: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid && s_axi_wlast) begin
               state_d  = ST_RESP;
               bvalid_d = 1'b1;
               bid_d    = head_id;
               bresp_d  = 2'b11;
            end
         end
         ST_RESP: begin
            if (m_decerr_bready) begin
               bvalid_d = 1'b0;
               cmd_pop  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign m_decerr_bvalid = bvalid_q;
   assign m_decerr_bid    = bid_q;
   assign m_decerr_bresp  = bresp_q;

`ifdef AXI_XBAR_W_ROUTE_REG_EN
   // Each skid entry carries its own select: the FSM may already be on the next command.
   logic [SEL_W-1:0]      sk_sel_q  [2];
   logic [DATA_WIDTH-1:0] sk_data_q [2];
   logic [STRB_WIDTH-1:0] sk_strb_q [2];
   logic                  sk_last_q [2];
   logic                  sk_wp_q, sk_rp_q;
   logic [1:0]            sk_cnt_q;
   logic                  sk_push, sk_pop, sk_out_vld;

   assign route_rdy  = (sk_cnt_q != 2'd2);
   assign sk_push    = route_vld & route_rdy;
   assign sk_out_vld = (sk_cnt_q != 2'd0);
   assign sk_pop     = sk_out_vld & m_axi_wready[sk_sel_q[sk_rp_q]];

   always_ff @(posedge clk) begin
      if (sk_push) begin
         sk_sel_q[sk_wp_q]  <= head_sel;
         sk_data_q[sk_wp_q] <= s_axi_wdata;
         sk_strb_q[sk_wp_q] <= s_axi_wstrb;
         sk_last_q[sk_wp_q] <= s_axi_wlast;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk_wp_q  <= 1'b0;
         sk_rp_q  <= 1'b0;
         sk_cnt_q <= 2'd0;
      end else begin
         if (sk_push) sk_wp_q <= ~sk_wp_q;
         if (sk_pop)  sk_rp_q <= ~sk_rp_q;
         sk_cnt_q <= sk_cnt_q + {1'b0, sk_push} - {1'b0, sk_pop};
      end
   end

   always_comb begin
      m_axi_wvalid                    = '0;
      m_axi_wvalid[sk_sel_q[sk_rp_q]] = sk_out_vld;
   end
   assign m_axi_wdata = sk_data_q[sk_rp_q];
   assign m_axi_wstrb = sk_strb_q[sk_rp_q];
   assign m_axi_wlast = sk_last_q[sk_rp_q];
`else
   assign route_rdy = m_axi_wready[head_sel];

   always_comb begin
      m_axi_wvalid           = '0;
      m_axi_wvalid[head_sel] = route_vld;
   end
   assign m_axi_wdata = s_axi_wdata;
   assign m_axi_wstrb = s_axi_wstrb;
   assign m_axi_wlast = s_axi_wlast;
`endif

endmodule

// File: tb/tb_axi_crossbar_w_route.sv
// Directed bench for axi_crossbar_w_route; a negedge monitor scores master W beats and DECERR responses.
module tb_axi_crossbar_w_route;
`ifdef AXI_XBAR_W_ROUTE_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  s_wc_select = '0;
   logic        s_wc_decerr = 1'b0;
   logic [7:0]  s_wc_id = '0;
   logic        s_wc_valid = 1'b0;
   logic        s_wc_ready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wlast;
   logic [3:0]  m_axi_wvalid;
   logic [3:0]  m_axi_wready = 4'hF;
   logic [7:0]  m_decerr_bid;
   logic [1:0]  m_decerr_bresp;
   logic        m_decerr_bvalid;
   logic        m_decerr_bready = 1'b0;

   axi_crossbar_w_route dut (
      .clk(clk), .rst(rst),
      .s_wc_select(s_wc_select), .s_wc_decerr(s_wc_decerr), .s_wc_id(s_wc_id),
      .s_wc_valid(s_wc_valid), .s_wc_ready(s_wc_ready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_decerr_bid(m_decerr_bid), .m_decerr_bresp(m_decerr_bresp),
      .m_decerr_bvalid(m_decerr_bvalid), .m_decerr_bready(m_decerr_bready)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [38:0] exp_w_q [$];
   logic [9:0]  exp_b_q [$];
   int          m_cyc_q [$];
   logic [38:0] mon_w;
   logic [9:0]  mon_b;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   // Scoreboard monitor: every handshake the DUT presents is matched against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         chk("wvalid_onehot0", {63'd0, $onehot0(m_axi_wvalid)}, 64'd1);
         for (int i = 0; i < 4; i++) begin
            if (m_axi_wvalid[i] && m_axi_wready[i]) begin
               m_cyc_q.push_back(cyc);
               if (exp_w_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_w_beat: port %0d data 0x%0h, expected none", i, m_axi_wdata);
               end else begin
                  mon_w = exp_w_q.pop_front();
                  chk("w_beat", {25'd0, i[1:0], m_axi_wdata, m_axi_wstrb, m_axi_wlast}, {25'd0, mon_w});
               end
            end
         end
         if (m_decerr_bvalid && m_decerr_bready) begin
            if (exp_b_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_b: bid 0x%0h, expected none", m_decerr_bid);
            end else begin
               mon_b = exp_b_q.pop_front();
               chk("b_resp", {54'd0, m_decerr_bid, m_decerr_bresp}, {54'd0, mon_b});
            end
         end
      end
   end

   task automatic exp_beat(input logic [1:0] sel, input logic [31:0] d, input logic last);
      exp_w_q.push_back({sel, d, d[3:0] ^ 4'h5, last});
   endtask

   task automatic push_cmd(input logic [1:0] sel, input logic dec, input logic [7:0] id);
      logic ok;
      ok = 1'b0;
      s_wc_select = sel; s_wc_decerr = dec; s_wc_id = id; s_wc_valid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (s_wc_ready) ok = 1'b1;
      end
      if (!ok) timeout("push_cmd");
      @(posedge clk); #1;
      s_wc_valid = 1'b0;
   endtask

   // Leaves wvalid asserted so consecutive calls form a back-to-back burst.
   task automatic send_beat(input logic [31:0] d, input logic last, output int hs);
      logic ok;
      ok = 1'b0;
      hs = -1;
      s_axi_wdata = d; s_axi_wstrb = d[3:0] ^ 4'h5; s_axi_wlast = last; s_axi_wvalid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (s_axi_wready) begin
            ok = 1'b1;
            hs = cyc;
         end
      end
      if (!ok) timeout("send_beat");
      @(posedge clk); #1;
   endtask

   task automatic drain_w(input string name);
      for (int k = 0; k < 100 && exp_w_q.size() != 0; k++) @(posedge clk);
      chk(name, exp_w_q.size(), 0);
   endtask

   initial begin
      int hs, hs0, hs_first, hs_last;
      int m0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wc_ready", s_wc_ready, 0);
      chk("rst_wvalid", m_axi_wvalid, 0);
      chk("rst_wready", s_axi_wready, 0);
      chk("rst_bvalid", m_decerr_bvalid, 0);
      chk("rst_bid", m_decerr_bid, 0);
      chk("rst_bresp", m_decerr_bresp, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("wc_ready_after_rst", s_wc_ready, 1);
      @(posedge clk); #1;

      // Routed burst to port 2
      push_cmd(2'd2, 1'b0, 8'h01);
      for (int b = 0; b < 4; b++) begin
         exp_beat(2'd2, 32'hA0 + b, b == 3);
         send_beat(32'hA0 + b, b == 3, hs);
      end
      s_axi_wvalid = 1'b0;
      drain_w("burst_sel2_drain");
      @(negedge clk); @(negedge clk);
      chk("head_popped_wready", s_axi_wready, 0);
      @(posedge clk); #1;

      // Decode-error burst: absorbed, then DECERR held until bready
      push_cmd(2'd0, 1'b1, 8'h5A);
      send_beat(32'h11, 1'b0, hs0);
      send_beat(32'h12, 1'b0, hs);
      send_beat(32'h13, 1'b1, hs);
      s_axi_wvalid = 1'b0;
      chk("discard_back_to_back", hs - hs0, 2);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("resp_bvalid_hold", m_decerr_bvalid, 1);
         chk("resp_bid_hold", m_decerr_bid, 8'h5A);
         chk("resp_bresp_hold", m_decerr_bresp, 2'b11);
         chk("resp_wready", s_axi_wready, 0);
      end
      @(posedge clk); #1;
      exp_b_q.push_back({8'h5A, 2'b11});
      m_decerr_bready = 1'b1;
      @(posedge clk); #1;
      m_decerr_bready = 1'b0;
      @(negedge clk);
      chk("bvalid_cleared", m_decerr_bvalid, 0);
      chk("b_drain", exp_b_q.size(), 0);
      @(posedge clk); #1;

      // Fill the command FIFO; a push in the pop cycle is refused
      push_cmd(2'd0, 1'b0, 8'h10);
      push_cmd(2'd1, 1'b0, 8'h11);
      push_cmd(2'd2, 1'b0, 8'h12);
      push_cmd(2'd3, 1'b0, 8'h13);
      @(negedge clk);
      chk("full_after_4", s_wc_ready, 0);
      @(posedge clk); #1;
      s_wc_select = 2'd1; s_wc_decerr = 1'b0; s_wc_id = 8'h15; s_wc_valid = 1'b1;
      exp_beat(2'd0, 32'hB0, 1'b1);
      s_axi_wdata = 32'hB0; s_axi_wstrb = 4'h0 ^ 4'h5; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      @(negedge clk);
      chk("pop_cycle_wready", s_axi_wready, 1);
      chk("full_at_pop", s_wc_ready, 0);
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0;
      @(negedge clk);
      chk("slot_freed", s_wc_ready, 1);
      @(posedge clk); #1;
      s_wc_valid = 1'b0;
      @(negedge clk);
      chk("refilled_once", s_wc_ready, 0);
      @(posedge clk); #1;
      exp_beat(2'd1, 32'hC1, 1'b1); send_beat(32'hC1, 1'b1, hs); s_axi_wvalid = 1'b0;
      exp_beat(2'd2, 32'hC2, 1'b1); send_beat(32'hC2, 1'b1, hs); s_axi_wvalid = 1'b0;
      exp_beat(2'd3, 32'hC3, 1'b1); send_beat(32'hC3, 1'b1, hs); s_axi_wvalid = 1'b0;
      exp_beat(2'd1, 32'hC4, 1'b1); send_beat(32'hC4, 1'b1, hs); s_axi_wvalid = 1'b0;
      drain_w("fifo_full_drain");

      // Master backpressure mid-burst on port 1
      push_cmd(2'd1, 1'b0, 8'h21);
      for (int b = 0; b < 4; b++) exp_beat(2'd1, 32'hD0 + b, b == 3);
      send_beat(32'hD0, 1'b0, hs);
      m_axi_wready = 4'b1101;
      s_axi_wdata = 32'hD1; s_axi_wstrb = 4'h1 ^ 4'h5; s_axi_wlast = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_wvalid1", m_axi_wvalid[1], 1);
`ifndef AXI_XBAR_W_ROUTE_REG_EN
         chk("stall_wready", s_axi_wready, 0);
`endif
         @(posedge clk); #1;
      end
      m_axi_wready = 4'hF;
      send_beat(32'hD1, 1'b0, hs);
      send_beat(32'hD2, 1'b0, hs);
      send_beat(32'hD3, 1'b1, hs);
      s_axi_wvalid = 1'b0;
      drain_w("stall_drain");

      // Reset during beat 2 of 4
      push_cmd(2'd0, 1'b0, 8'h31);
`ifndef AXI_XBAR_W_ROUTE_REG_EN
      exp_beat(2'd0, 32'hE0, 1'b0);
`endif
      send_beat(32'hE0, 1'b0, hs);
      s_axi_wdata = 32'hE1; s_axi_wstrb = 4'h1 ^ 4'h5; s_axi_wlast = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_wvalid", m_axi_wvalid, 0);
      chk("midrst_wready", s_axi_wready, 0);
      chk("midrst_wc_ready", s_wc_ready, 0);
      chk("midrst_bvalid", m_decerr_bvalid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("postrst_wc_ready", s_wc_ready, 1);
         chk("postrst_wready", s_axi_wready, 0);
         chk("postrst_wvalid", m_axi_wvalid, 0);
      end
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0;
      chk("midrst_w_queue", exp_w_q.size(), 0);

      // 8-beat back-to-back burst: latency and throughput
      push_cmd(2'd3, 1'b0, 8'h41);
      m_cyc_q.delete();
      for (int b = 0; b < 8; b++) exp_beat(2'd3, 32'hF0 + b, b == 7);
      send_beat(32'hF0, 1'b0, hs_first);
      for (int b = 1; b < 8; b++) send_beat(32'hF0 + b, b == 7, hs_last);
      s_axi_wvalid = 1'b0;
      drain_w("burst8_drain");
      chk("burst8_slave_span", hs_last - hs_first, 7);
      chk("burst8_master_count", m_cyc_q.size(), 8);
      if (m_cyc_q.size() == 8) begin
         m0 = m_cyc_q[0];
         chk("burst8_first_latency", m0 - hs_first, LAT);
         chk("burst8_master_span", m_cyc_q[7] - m0, 7);
      end else begin
         timeout("burst8_master_beats");
      end

      repeat (3) @(posedge clk);
      chk("final_w_queue", exp_w_q.size(), 0);
      chk("final_b_queue", exp_b_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end
endmodule
